// File: rtl/lfsr_checker_if.sv
// Stream-side signal bundle for lfsr_checker: received bit stream in, lock/error status out.
interface lfsr_checker_if #(
   parameter int ErrWidth = 16
);
   logic                enable;
   logic                in;
   logic                clear_count;
   logic                locked;
   logic                bit_error;
   logic [ErrWidth-1:0] error_count;

   modport master (
      output enable, in, clear_count,
      input  locked, bit_error, error_count
   );

   modport slave (
      input  enable, in, clear_count,
      output locked, bit_error, error_count
   );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: fills a history from the received stream, verifies
// LockCount correct predictions, then free-runs a local generator and counts mismatches.
module lfsr_checker #(
   parameter int               Depth      = 8,
   parameter logic [Depth-1:0] Coeffs     = 8'b10111000,
   parameter int               LockCount  = 16,
   parameter int               LossThresh = 4,
   parameter int               ErrWidth   = 16
) (
   input  logic          clk,
   input  logic          reset,
   lfsr_checker_if.slave bus
);

   localparam int FW = $clog2(Depth + 1);
   localparam int SW = $clog2(LockCount + 1);
   localparam int RW = $clog2(LossThresh + 1);

   localparam logic [FW-1:0] FILL_LAST = FW'(Depth - 1);
   localparam logic [SW-1:0] SYNC_LAST = SW'(LockCount - 1);
   localparam logic [RW-1:0] RUN_LAST  = RW'(LossThresh - 1);

   localparam logic [1:0] ST_FILL   = 2'd0;
   localparam logic [1:0] ST_SYNC   = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [Depth-1:0]    h_q, h_d;
   logic [FW-1:0]       fill_q, fill_d;
   logic [SW-1:0]       sync_q, sync_d;
   logic [RW-1:0]       run_q, run_d;
   logic [ErrWidth-1:0] cnt_q, cnt_d;
   logic                berr_q, berr_d;
   logic                locked_q, locked_d;
   logic                pred;

   function automatic logic [ErrWidth-1:0] sat_inc(input logic [ErrWidth-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   assign pred = ^(h_q & Coeffs);

   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      fill_d   = fill_q;
      sync_d   = sync_q;
      run_d    = run_q;
      cnt_d    = cnt_q;
      berr_d   = 1'b0;
      locked_d = locked_q;
      if (bus.enable) begin
         case (state_q)
            ST_FILL: begin
               h_d    = {h_q[Depth-2:0], bus.in};
               fill_d = fill_q + 1'b1;
               if (fill_q == FILL_LAST) begin
                  state_d = ST_SYNC;
                  sync_d  = '0;
               end
            end
            ST_SYNC: begin
               h_d = {h_q[Depth-2:0], bus.in};
               // An all-zero history predicts zero forever, so it must never count toward lock.
               if ((bus.in == pred) && (h_q != '0)) begin
                  sync_d = sync_q + 1'b1;
                  if (sync_q == SYNC_LAST) begin
                     state_d  = ST_LOCKED;
                     run_d    = '0;
                     locked_d = 1'b1;
                  end
               end else begin
                  sync_d = '0;
               end
            end
            ST_LOCKED: begin
               // Shift the prediction, not the received bit, so one channel error counts once.
               h_d = {h_q[Depth-2:0], pred};
               if (bus.in != pred) begin
                  berr_d = 1'b1;
                  cnt_d  = sat_inc(cnt_q);
                  run_d  = run_q + 1'b1;
                  if (run_q == RUN_LAST) begin
                     state_d  = ST_FILL;
                     fill_d   = '0;
                     locked_d = 1'b0;
                  end
               end else begin
                  run_d = '0;
               end
            end
            default: begin
               state_d  = ST_FILL;
               fill_d   = '0;
               locked_d = 1'b0;
            end
         endcase
      end
      if (bus.clear_count) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_FILL;
         h_q      <= '0;
         fill_q   <= '0;
         sync_q   <= '0;
         run_q    <= '0;
         cnt_q    <= '0;
         berr_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         fill_q   <= fill_d;
         sync_q   <= sync_d;
         run_q    <= run_d;
         cnt_q    <= cnt_d;
         berr_q   <= berr_d;
         locked_q <= locked_d;
      end
   end

   assign bus.locked      = locked_q;
   assign bus.bit_error   = berr_q;
   assign bus.error_count = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a 16-bit-count and a 4-bit-count instance see the same stream.
module tb_lfsr_checker;
   localparam logic [7:0] COEFFS = 8'b10111000;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   pulses_a = 0;
   int   pulses_b = 0;
   int   saw_lock = 0;
   logic [7:0] g = 8'h5A;

   lfsr_checker_if #(.ErrWidth(16)) ia ();
   lfsr_checker_if #(.ErrWidth(4))  ib ();

   lfsr_checker #(.Depth(8), .Coeffs(COEFFS), .LockCount(16), .LossThresh(4), .ErrWidth(16))
      dut_a (.clk(clk), .reset(reset), .bus(ia));
   lfsr_checker #(.Depth(8), .Coeffs(COEFFS), .LockCount(16), .LossThresh(4), .ErrWidth(4))
      dut_b (.clk(clk), .reset(reset), .bus(ib));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic b, input logic clr);
      @(negedge clk);
      ia.enable = en;  ib.enable = en;
      ia.in = b;       ib.in = b;
      ia.clear_count = clr;
      ib.clear_count = clr;
      @(posedge clk);
      #1;
      if (ia.bit_error) pulses_a++;
      if (ib.bit_error) pulses_b++;
      if (ia.locked) saw_lock = 1;
   endtask

   // Reference transmitter: Fibonacci lfsr, newest bit in g[0].
   task automatic send(input logic flip, input logic clr);
      logic nb;
      nb = ^(g & COEFFS);
      g  = {g[6:0], nb};
      drive(1'b1, nb ^ flip, clr);
   endtask

   task automatic idle();
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) send(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      ia.enable = 1'b0;
      ib.enable = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      ia.enable = 1'b0; ia.in = 1'b0; ia.clear_count = 1'b0;
      ib.enable = 1'b0; ib.in = 1'b0; ib.clear_count = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked",    32'(ia.locked), 0);
      chk("rst_bit_error", 32'(ia.bit_error), 0);
      chk("rst_count_a",   32'(ia.error_count), 0);
      chk("rst_count_b",   32'(ib.error_count), 0);
      @(negedge clk);
      reset = 1'b1;

      clean(23);
      chk("lock_bit23", 32'(ia.locked), 0);
      send(1'b0, 1'b0);
      chk("lock_bit24_a", 32'(ia.locked), 1);
      chk("lock_bit24_b", 32'(ib.locked), 1);

      pulses_a = 0;
      clean(510);
      chk("clean_pulses", pulses_a, 0);
      chk("clean_count",  32'(ia.error_count), 0);
      chk("clean_locked", 32'(ia.locked), 1);

      clean(99);
      send(1'b1, 1'b0);
      chk("single_strobe", 32'(ia.bit_error), 1);
      chk("single_count",  32'(ia.error_count), 1);
      chk("single_locked", 32'(ia.locked), 1);
      send(1'b0, 1'b0);
      chk("single_strobe_off", 32'(ia.bit_error), 0);
      clean(20);
      chk("single_pulses", pulses_a, 1);
      chk("single_count2", 32'(ia.error_count), 1);

      send(1'b0, 1'b1);
      chk("clear_count",  32'(ia.error_count), 0);
      chk("clear_locked", 32'(ia.locked), 1);

      for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
      chk("loss_3rd_locked", 32'(ia.locked), 1);
      send(1'b1, 1'b0);
      chk("loss_4th_locked", 32'(ia.locked), 0);
      chk("loss_4th_strobe", 32'(ia.bit_error), 1);
      chk("loss_count",      32'(ia.error_count), 4);

      pulses_a = 0;
      clean(23);
      chk("relock_bit23", 32'(ia.locked), 0);
      send(1'b0, 1'b0);
      chk("relock_bit24", 32'(ia.locked), 1);
      chk("relock_no_strobe", pulses_a, 0);

      @(negedge clk);
      ia.enable = 1'b0;
      ib.enable = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("midrst_locked", 32'(ia.locked), 0);
      chk("midrst_strobe", 32'(ia.bit_error), 0);
      chk("midrst_count",  32'(ia.error_count), 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 23; i++) begin
         send(1'b0, 1'b0);
         idle();
      end
      chk("gap_bit23", 32'(ia.locked), 0);
      send(1'b0, 1'b0);
      chk("gap_bit24", 32'(ia.locked), 1);
      idle();
      chk("gap_idle_locked", 32'(ia.locked), 1);
      chk("gap_idle_strobe", 32'(ia.bit_error), 0);

      do_reset();
      saw_lock = 0;
      pulses_a = 0;
      for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 1'b0);
      chk("zero_never_lock", saw_lock, 0);
      chk("zero_no_strobe",  pulses_a, 0);

      do_reset();
      clean(24);
      chk("sat_lock", 32'(ib.locked), 1);
      for (int i = 0; i < 20; i++) begin
         send(1'b1, 1'b0);
         clean(3);
      end
      chk("sat_count_b", 32'(ib.error_count), 15);
      chk("sat_count_a", 32'(ia.error_count), 20);
      chk("sat_locked",  32'(ib.locked), 1);
      idle();
      chk("sat_idle_strobe", 32'(ib.bit_error), 0);
      chk("sat_idle_count",  32'(ib.error_count), 15);
      send(1'b1, 1'b1);
      chk("clr_win_b",      32'(ib.error_count), 0);
      chk("clr_win_a",      32'(ia.error_count), 0);
      chk("clr_win_strobe", 32'(ia.bit_error), 1);
      chk("clr_win_locked", 32'(ia.locked), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Self-synchronising PRBS checker: the receive-side counterpart of `lfsr`. It takes a serial bit stream produced by an `lfsr` configured with the same `Depth`/`Coeffs`, acquires the sequence from the received bits, and then checks every later bit against a locally generated prediction. It reports lock, a per-bit error strobe and a saturating error count. It sits at the far end of a link or loopback path under test.

## Interface
- `Depth`, 8: sequence order (bits of history), ≥ 2.
- `Coeffs`, 8'b10111000: tap mask, `Depth` bits. `Coeffs[k]`=1 means the term b[n-k-1] is in the recurrence.
- `LockCount`, 16: consecutive correct predictions required to declare lock, ≥ 1.
- `LossThresh`, 4: consecutive errored bits while locked that force loss of lock, ≥ 1.
- `ErrWidth`, 16: width of `error_count`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  active-high; `in` is a valid stream bit this cycle.
- `in`  in  1  received stream bit.
- `clear_count`  in  1  synchronous clear of `error_count`.
- `locked`  out  1  high while the checker is in LOCKED.
- `bit_error`  out  1  one-cycle strobe for a mismatched bit while LOCKED.
- `error_count`  out  ErrWidth  saturating count of errored bits seen while LOCKED.

## Operation
- Stream model: b[n] = XOR over k with `Coeffs[k]`=1 of b[n-k-1]. This is the sequence `lfsr` emits on `out`.
- History register h[Depth-1:0] holds the last `Depth` bits, with h[0] the newest. Prediction: pred = ^(h & Coeffs).
- Cycles with `enable`=0 change nothing: no state change and no output pulse.
- FILL (the reset state):
  - Each enabled bit shifts `in` into h and increments fill_cnt.
  - When `Depth` bits have been accepted, go to SYNC with sync_cnt=0.
- SYNC:
  - Each enabled bit shifts `in` into h.
  - If `in`==pred and h≠0, sync_cnt++. Otherwise sync_cnt=0. An all-zero history never counts toward lock.
  - When sync_cnt reaches `LockCount`, go to LOCKED with err_run=0.
- LOCKED:
  - Each enabled bit shifts pred, not `in`, into h. The local generator free-runs, so one channel error is counted exactly once.
  - Mismatch (`in`≠pred): `bit_error`=1, `error_count`++ (saturating at all-ones), err_run++.
  - Match: err_run=0.
  - When err_run reaches `LossThresh`, go to FILL with fill_cnt=0. The error that reached the threshold is still counted.
- `clear_count` sets `error_count` to 0 and wins over a same-cycle increment. It does not affect state or lock.
- Asynchronous reset forces FILL and clears h, all counters and all outputs, including in the middle of a lock.

## Timing
- Reset values: `locked`=0, `bit_error`=0, `error_count`=0.
- All outputs are registered. `bit_error` and `error_count` reflect the enabled bit sampled on the same rising edge, so they are visible one cycle after `in` is driven.
- `locked` rises on the edge that accepts enabled bit number `Depth`+`LockCount` after reset or loss of lock, provided every SYNC bit is correct.
- `locked` falls on the edge that accepts the `LossThresh`-th consecutive errored bit. `bit_error` is also high for that bit.
- `bit_error` is never high in FILL or SYNC. It is low on every cycle with `enable`=0.
- Reset release is synchronised by the system: the first valid `enable` arrives at least one cycle after `reset` deasserts.

## Test plan
- Lock and clean run: drive `lfsr` (Depth 8, Coeffs 8'b10111000, Galois 0) from a nonzero state into `in` with `enable`=1 → `locked` rises after bit 24; over the following 510 bits `bit_error` stays 0 and `error_count` stays 0.
- Single error: invert one bit 100 bits after lock → exactly one `bit_error` pulse, `error_count`=1, `locked` stays 1.
- Loss and relock: invert 4 consecutive bits → `locked` falls on the 4th, `error_count`=4. With a clean stream, `locked` rises again 24 bits later.
- Zero stream and gaps: all-zero `in` for 300 bits → `locked` never rises. With `enable` toggled 1/0 on a clean stream → lock takes 24 enabled bits and is unaffected by idle cycles.
- Saturation and clear: use `ErrWidth`=4 and inject 20 isolated errors → `error_count`=15. Assert `clear_count` in the same cycle as a further error → `error_count`=0.
- Reset mid-lock: assert `reset` low between clock edges while locked → `locked`, `bit_error` and `error_count` go to 0 immediately. After release, relock takes 24 bits.
